// File: rtl/div_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
// Imported by the divider top and its trial-subtract step.
package div_pkg;

    localparam int DivDataW = 32;
    localparam int DivCntW  = 6;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivSigned         = 1'b1;
    localparam logic DivUnsigned       = 1'b0;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [63:0] DoubleZero = 64'h0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compares the widened partial remainder
// against the divisor and returns the difference for the restore decision.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DivDataW
) (
    input  logic [DATA_W:0]   partial_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              ge_o,
    output logic [DATA_W:0]   diff_o
);

    logic [DATA_W:0] divisor_ext;

    always_comb begin
        divisor_ext = {1'b0, divisor_i};
        ge_o        = (partial_i >= divisor_ext);
        diff_o      = partial_i - divisor_ext;
    end

endmodule

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: latches operand magnitudes, runs
// DATA_W trial-subtract steps, then applies MIPS sign rules to {rem, quo}.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DivDataW,
    parameter int CNT_W  = DivCntW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;    // dividend, shifted out as quotient shifts in
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     partial;
    logic [DATA_W:0]     diff;
    logic                ge;
    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign partial = {rem_q, dvd_q[DATA_W-1]};

    div_step #(.DATA_W(DATA_W)) u_step (
        .partial_i (partial),
        .divisor_i (dvs_q),
        .ge_o      (ge),
        .diff_o    (diff)
    );

    always_comb begin
        op1_neg = (signed_div_i == DivSigned) && opdata1_i[DATA_W-1];
        op2_neg = (signed_div_i == DivSigned) && opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag = op2_neg ? -opdata2_i : opdata2_i;
        quo_fix = neg_quo_q ? -dvd_q : dvd_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (start_i == DivStart && !annul_i) begin
                    state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
                    cnt_d     = '0;
                    dvd_d     = op1_mag;
                    dvs_d     = op2_mag;
                    rem_d     = '0;
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                end
            end
            DivByZero: begin
                result_d = '0;
                if (annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end else begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    cnt_d    = '0;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else if (cnt_q != LastCnt) begin
                    rem_d = ge ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], ge};
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = DivEnd;
                    cnt_d    = '0;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                // annul_i deliberately ignored: the result is already committed
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: hand-computed {rem, quo} vectors, latency,
// divide-by-zero, annul, synchronous reset and back-to-back requests.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total;
    int bad;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble operands after the accept edge, count edges
    // (accept edge inclusive) until ready, then optionally drop start.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input bit drop);
        int n;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        step();
        n = 1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        while (ready_o !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        if (drop) begin
            start_i = 1'b0;
            step();
            check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
            check({tag, "_drop_res"}, result_o, 64'd0);
        end
    endtask

    initial begin
        bit seen;
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        step();
        step();
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o, 64'd0);
        rst = 1'b1;
        step();

        do_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b1);
        do_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b1);
        do_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34, 1'b1);
        do_div("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 34, 1'b1);
        do_div("div_by_zero", 1'b0, 32'd55, 32'd0, 64'd0, 2, 1'b1);
        do_div("udiv_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'h7FFF_FFFF}, 34, 1'b1);
        do_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34, 1'b1);
        do_div("udiv_small", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 34, 1'b1);

        // Annul at iteration 10: no result may appear afterwards
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        annul_i = 1'b1;
        start_i = 1'b0;
        step();
        annul_i = 1'b0;
        check("annul_rdy", 64'(ready_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o === 1'b1) seen = 1'b1;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 1'b1);

        // Reset at iteration 20
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        rst     = 1'b0;
        start_i = 1'b0;
        step();
        check("rst_mid_rdy", 64'(ready_o), 64'd0);
        check("rst_mid_res", result_o, 64'd0);
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o === 1'b1) seen = 1'b1;
        end
        check("rst_never_ready", 64'(seen), 64'd0);

        // Sync reset: holding result in DivEnd, reset without an edge changes nothing
        do_div("hold_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b0);
        annul_i = 1'b1;
        step();
        annul_i = 1'b0;
        check("hold_annul_ignored", result_o, {32'd2, 32'd14});
        rst = 1'b0;
        #2;
        check("sync_rst_rdy", 64'(ready_o), 64'd1);
        check("sync_rst_res", result_o, {32'd2, 32'd14});
        @(posedge clk);
        #1;
        check("sync_rst_edge_rdy", 64'(ready_o), 64'd0);
        check("sync_rst_edge_res", result_o, 64'd0);
        rst     = 1'b1;
        start_i = 1'b0;
        step();

        // Back-to-back: one start_i=0 edge between requests
        do_div("b2b_a", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 34, 1'b1);
        do_div("b2b_b", 1'b1, 32'hFFFF_FFB3, 32'd10, {32'hFFFF_FFF9, 32'hFFFF_FFF9}, 34, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit divider that serves DIV/DIVU for the EX stage.
- EX is the initiator: it drives operands plus start_i, and holds its pipeline stall request until ready_o is seen.
- Responder implementation: radix-2 restoring (trial-subtraction) FSM, one quotient bit per cycle.
- Result returns as {remainder, quotient}, destined for HI/LO.

Parameters:
- DATA_W, 32: operand width; iteration count equals DATA_W.
- CNT_W, 6: width of iteration counter; must hold the value DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request level; EX holds it high until ready_o is seen, then drops it.
- annul_i  in  1  cancel in-flight division (flush / branch-delay cancel).
- result_o  out  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:

Clock and reset
- One clock, clk. Reset rst is synchronous and active-low.
- rst=0 at an edge: state=DivFree, cnt=0, internal dividend/divisor regs=0, result_o=0, ready_o=0.
- Reset wins over every other input, including mid-division.

States (2-bit): DivFree, DivByZero, DivOn, DivEnd.

DivFree
- start_i=1 and annul_i=0:
  - opdata2_i==0 -> DivByZero.
  - otherwise -> DivOn, cnt=0.
  - Latch magnitudes. If signed_div_i=1, a negative operand is replaced by its two's complement. Unsigned operands are latched as-is.
  - Latch sign flags.
- Otherwise stay; ready_o=0, result_o=0.

DivByZero
- Next edge -> DivEnd with ready_o=1 and result_o=0.
- annul_i=1 -> DivFree instead.

DivOn
- annul_i=1 at any edge -> DivFree, ready_o=0, result discarded.
- cnt<DATA_W: one step per edge.
  - Partial remainder = shift-in of the next dividend MSB.
  - If partial remainder >= divisor: subtract, quotient bit=1; else quotient bit=0.
  - cnt++.
- cnt==DATA_W: finalization edge.
  - Quotient negated if signed and the operand signs differ.
  - Remainder negated if signed and the dividend is negative.
  - result_o={rem, quo}, ready_o=1, -> DivEnd, cnt=0.

DivEnd
- Hold result_o and ready_o while start_i=1.
- start_i=0 at an edge -> DivFree, ready_o=0, result_o=0.
- annul_i is ignored here.

Latency
- Start sampled at edge E0. ready_o is visible after edge E0+DATA_W+1, i.e. 34 edges inclusive for DATA_W=32.
- Divide-by-zero: ready_o after E0+1.

Arithmetic rules
- Quotient truncates toward zero; remainder takes the dividend's sign (MIPS semantics).
- Signed 0x80000000 / 0xFFFFFFFF yields quo=0x80000000, rem=0. No trap.
- Divisor==0 gives result 0; the architecture leaves this undefined, so it is fixed here for determinism.

Input stability and back-to-back use
- Operand and signed_div_i changes after E0 are ignored; latched copies are used.
- Back-to-back: a new start needs at least one edge with start_i=0 (the DivEnd -> DivFree transition). DivFree then accepts on the following edge.

Decomposition:
- Shared defines package:
  - state codes DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
  - DivResultReady/NotReady, DivStart/DivStop, DivSigned/DivUnsigned;
  - ZeroWord, DoubleZero.
- Optional sub-module div_step: combinational DATA_W+1-bit trial subtract returning {ge, diff}. The FSM, counter and sign fix stay in div.

Test Plan:
1. Unsigned 100/7 (start held):
   - ready_o rises exactly 34 edges after start sampled.
   - result_o = {0x00000002, 0x0000000E}.
   - Drop start -> ready_o=0, result_o=0 next edge.
2. Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o = 64'hFFFFFFFF_FFFFFFFD (rem -1, quo -3). Signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
3. Divide-by-zero: opdata2=0, start=1 -> ready_o=1 two edges after sampling, result_o=0. Unsigned 0xFFFFFFFF/2 -> {0x00000001, 0x7FFFFFFF}.
4. Overflow: signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
5. Annul at iteration 10 -> DivFree next edge, ready_o never asserts. A following 9/3 request completes normally with {0, 3}.
6. rst=0 at iteration 20 -> all outputs 0 on that edge. Reset asserted without a clock edge has no effect (sync check). Back-to-back requests separated by one start_i=0 cycle both complete.
